// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
//
// Ports:
//   Clk      - clock, rising edge
//   Reset    - asynchronous, active-high reset
//   Start    - begin an operation (sampled only when idle)
//   Op       - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B     - operands (multiplicand/dividend, multiplier/divisor)
//   HI_We    - MTHI: load Wr_Data into HI when idle
//   LO_We    - MTLO: load Wr_Data into LO when idle
//   Wr_Data  - data for MTHI/MTLO
//   Busy     - operation in progress (CALC or FIN)
//   Done     - one-cycle pulse after HI/LO receive a result
//   HI, LO   - product high/low word, or remainder/quotient
//
// One shift-add or restoring-divide step per cycle for 32 cycles, then a
// sign-fixup cycle that commits the result. Operation latency is 33 edges.
module muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HI_We,
  input  logic        LO_We,
  input  logic [31:0] Wr_Data,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;   // {partial hi, multiplier} or {remainder, quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand magnitudes; signs only count for the signed ops (Op[0]).
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = Op[0] & A[31];
  assign b_neg = Op[0] & B[31];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Shift-add multiply step.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'h0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide step. When the subtraction succeeds the difference is
  // below the divisor, so 32 bits are enough to hold it.
  logic [32:0] div_shift;
  logic        div_ok;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ok    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift[31:0] - opb_q;
  assign div_next  = {(div_ok ? div_diff : div_shift[31:0]), acc_q[30:0], div_ok};

  // Sign fixup. With a zero divisor every step "succeeds", so the remainder
  // ends up as the dividend magnitude and re-applying the dividend sign
  // restores A exactly; only the quotient needs overriding.
  logic [63:0] mul_res;
  logic [31:0] div_lo, div_hi;
  assign mul_res = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign div_lo  = (opb_q == 32'h0)     ? 32'hFFFF_FFFF :
                   (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
  assign div_hi  = sign_a_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (HI_We) hi_d = Wr_Data;
        if (LO_We) lo_d = Wr_Data;
        if (Start) begin
          op_d     = Op;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          cnt_d    = 5'd0;
          if (Op[1]) begin
            opb_d = b_mag;
            acc_d = {32'h0, a_mag};
          end else begin
            opb_d = a_mag;
            acc_d = {32'h0, b_mag};
          end
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFin;
      end
      StFin: begin
        if (op_q[1]) begin
          hi_d = div_hi;
          lo_d = div_lo;
        end else begin
          hi_d = mul_res[63:32];
          lo_d = mul_res[31:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opb_q    <= 32'h0;
      acc_q    <= 64'h0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy = (state_q == StCalc) || (state_q == StFin);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed vectors, latency,
// Busy/Done timing, MTHI/MTLO, ignored mid-operation requests and reset abort.
module tb_muldiv_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HI_We;
  logic        LO_We;
  logic [31:0] Wr_Data;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;

  muldiv_unit dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .HI_We   (HI_We),
    .LO_We   (LO_We),
    .Wr_Data (Wr_Data),
    .Busy    (Busy),
    .Done    (Done),
    .HI      (HI),
    .LO      (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one operation from an idle edge E0 and returns the edge index at
  // which Done was seen (-1 if never). inj_e > 0 drives a conflicting Start
  // at that edge and an MTHI at edge inj_e+5. we0 issues MTHI at E0 too.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_e, input logic we0, output int lat);
    lat = -1;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    HI_We = we0; Wr_Data = 32'hAAAA_5555;
    @(posedge Clk);
    #1;
    check_eq("busy_e0", 64'(Busy), 64'd1);
    if (we0) check_eq("mthi_with_start", 64'(HI), 64'hAAAA_5555);
    for (int e = 1; e <= 40; e++) begin
      @(negedge Clk);
      Start = 1'b0; HI_We = 1'b0;
      if (inj_e > 0 && e == inj_e) begin
        Start = 1'b1; Op = 2'b10; A = 32'd5; B = 32'd1;
      end
      if (inj_e > 0 && e == inj_e + 5) begin
        HI_We = 1'b1; Wr_Data = 32'h1234_5678;
      end
      @(posedge Clk);
      #1;
      if (e == 32) check_eq("busy_e32", 64'(Busy), 64'd1);
      if (Done) begin
        lat = e;
        break;
      end
    end
    check_eq("busy_after", 64'(Busy), 64'd0);
    @(negedge Clk);
    Start = 1'b0; HI_We = 1'b0; LO_We = 1'b0;
    @(posedge Clk);
    #1;
    check_eq("done_one_cycle", 64'(Done), 64'd0);
  endtask

  int lat;
  int done_seen;

  initial begin
    checks = 0; failures = 0;
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = 32'h0; B = 32'h0;
    HI_We = 1'b0; LO_We = 1'b0; Wr_Data = 32'h0;
    #1;
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_done", 64'(Done), 64'd0);
    check_eq("rst_hilo", {HI, LO}, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;

    // MULTU max * max
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, lat);
    check_eq("multu_lat", 64'(lat), 64'd33);
    check_eq("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

    // MULT -3 * 5
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 0, 1'b0, lat);
    check_eq("mult_lat", 64'(lat), 64'd33);
    check_eq("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);

    // DIV -7 / 2 = -3 rem -1
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, lat);
    check_eq("div_neg_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV 7 / -2 = -3 rem 1
    run_op(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 0, 1'b0, lat);
    check_eq("div_negdiv_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFFD);

    // DIVU 100 / 0
    run_op(2'b10, 32'h0000_0064, 32'h0, 0, 1'b0, lat);
    check_eq("divu_zero_hilo", {HI, LO}, 64'h0000_0064_FFFF_FFFF);

    // DIV -8 / 0: HI must be A unmodified
    run_op(2'b11, 32'hFFFF_FFF8, 32'h0, 0, 1'b0, lat);
    check_eq("div_zero_hilo", {HI, LO}, 64'hFFFF_FFF8_FFFF_FFFF);

    // DIV overflow case
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, lat);
    check_eq("div_ovf_hilo", {HI, LO}, 64'h0000_0000_8000_0000);

    // DIVU 1000 / 7 = 142 rem 6
    run_op(2'b10, 32'd1000, 32'd7, 0, 1'b0, lat);
    check_eq("divu_hilo", {HI, LO}, {32'd6, 32'd142});

    // MULTU 0x1000 * 0x100001 with Start at E5 and MTHI at E10 ignored
    run_op(2'b00, 32'h0000_1000, 32'h0010_0001, 5, 1'b0, lat);
    check_eq("busy_ign_lat", 64'(lat), 64'd33);
    check_eq("busy_ign_hilo", {HI, LO}, 64'h0000_0001_0000_1000);

    // Idle MTHI then MTLO
    @(negedge Clk);
    HI_We = 1'b1; Wr_Data = 32'hDEAD_BEEF;
    @(posedge Clk);
    #1;
    check_eq("mthi_hilo", {HI, LO}, 64'hDEAD_BEEF_0000_1000);
    check_eq("mthi_busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    HI_We = 1'b0; LO_We = 1'b1; Wr_Data = 32'hCAFE_F00D;
    @(posedge Clk);
    #1;
    check_eq("mtlo_hilo", {HI, LO}, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge Clk);
    LO_We = 1'b0;

    // Start and MTHI on the same edge: both happen, result wins at E33
    run_op(2'b00, 32'd3, 32'd4, 0, 1'b1, lat);
    check_eq("start_mthi_hilo", {HI, LO}, 64'h0000_0000_0000_000C);

    // Leave non-zero HI/LO, then abort a DIVU with reset at E10
    run_op(2'b10, 32'd1000, 32'd7, 0, 1'b0, lat);
    @(negedge Clk);
    Start = 1'b1; Op = 2'b10; A = 32'd100; B = 32'd7;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check_eq("abort_busy", 64'(Busy), 64'd0);
    check_eq("abort_hilo", {HI, LO}, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (Done) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    check_eq("abort_hilo_hold", {HI, LO}, 64'h0);

    run_op(2'b00, 32'd3, 32'd4, 0, 1'b0, lat);
    check_eq("post_rst_lat", 64'(lat), 64'd33);
    check_eq("post_rst_hilo", {HI, LO}, 64'h0000_0000_0000_000C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
